pixel_grayscaler: RTL and testbench

PIXEL_GRAYSCALER -- requirements
Module: pixel_grayscaler

---
 rtl/pixel_pkg.sv | 24 ++
 rtl/pixel_grayscaler_gray_mac.sv | 26 ++
 rtl/pixel_grayscaler.sv | 99 +++++++++
 tb/tb_pixel_grayscaler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared constants and types for the RGB-to-grayscale converter.
// Build option GRAY_ROUND_EN selects round-to-nearest in gray_mac.
package pixel_pkg;

  localparam int N_DEF = 450;
  localparam int M_DEF = 600;

  // Luma weights scaled by 256: 77 + 150 + 29 = 256
  localparam logic [15:0] COEF_R = 16'd77;
  localparam logic [15:0] COEF_G = 16'd150;
  localparam logic [15:0] COEF_B = 16'd29;

  localparam logic [1:0] R_IDX = 2'd0;
  localparam logic [1:0] G_IDX = 2'd1;
  localparam logic [1:0] B_IDX = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_grayscaler_gray_mac.sv
// Combinational weighted sum of one RGB pixel reduced to an 8-bit gray level.
// Build option GRAY_ROUND_EN: round to nearest instead of truncating.
module gray_mac
  import pixel_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] gray
);

  logic [15:0] sum;

  // Maximum sum is 256*255, so the 16-bit result never wraps, even with +128
  function automatic logic [7:0] scale_gray(input logic [15:0] s);
`ifdef GRAY_ROUND_EN
    return 8'((s + 16'd128) >> 8);
`else
    return s[15:8];
`endif
  endfunction

  assign sum  = COEF_R * {8'h00, r} + COEF_G * {8'h00, g} + COEF_B * {8'h00, b};
  assign gray = scale_gray(sum);

endmodule

// File: rtl/pixel_grayscaler.sv
// Frame-level RGB-to-grayscale converter: collects R,G,B bytes, computes gray, hands it off.
// Build option GRAY_ROUND_EN (see gray_mac) changes only the arithmetic, not the timing.
module pixel_grayscaler
  import pixel_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       pause,
  output logic [7:0] gray_data,
  output logic       gray_valid,
  input  logic       gray_ready,
  output logic       done
);

  localparam int PIXELS = N * M;
  localparam int CNT_W  = $clog2(PIXELS + 1);

  state_t           state;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] pix_cnt;
  logic [7:0]       r;
  logic [7:0]       g;
  logic [7:0]       b;
  logic [7:0]       gray_next;
  logic             last_pix;

  gray_mac u_mac (
    .r    (r),
    .g    (g),
    .b    (b),
    .gray (gray_next)
  );

  assign last_pix   = (pix_cnt == CNT_W'(PIXELS - 1));
  assign pause      = (state != COLLECT);
  assign gray_valid = (state == OUTPUT);
  // done marks the accepting cycle of the final pixel, so it follows gray_ready
  assign done       = (state == OUTPUT) && gray_ready && last_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_idx  <= R_IDX;
      pix_cnt   <= '0;
      r         <= 8'h00;
      g         <= 8'h00;
      b         <= 8'h00;
      gray_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            byte_idx <= R_IDX;
            pix_cnt  <= '0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            case (byte_idx)
              R_IDX: begin
                r        <= in_data;
                byte_idx <= G_IDX;
              end
              G_IDX: begin
                g        <= in_data;
                byte_idx <= B_IDX;
              end
              default: begin
                b        <= in_data;
                byte_idx <= R_IDX;
                state    <= COMPUTE;
              end
            endcase
          end
        end
        COMPUTE: begin
          gray_data <= gray_next;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (gray_ready) begin
            pix_cnt  <= pix_cnt + 1'b1;
            byte_idx <= R_IDX;
            state    <= last_pix ? IDLE : COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_grayscaler.sv
// Directed-random bench for pixel_grayscaler on a 2x3 frame, checked against an arithmetic luma model.
module tb_pixel_grayscaler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       pause;
  logic [7:0] gray_data;
  logic       gray_valid;
  logic       gray_ready;
  logic       done;

  int checks = 0;
  int failures = 0;

  pixel_grayscaler #(.N(2), .M(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .pause      (pause),
    .gray_data  (gray_data),
    .gray_valid (gray_valid),
    .gray_ready (gray_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic int model(input int r, input int g, input int b);
    int s = 77 * r + 150 * g + 29 * b;
`ifdef GRAY_ROUND_EN
    s = s + 128;
`endif
    return s / 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUT in COLLECT waiting for an R byte
  task automatic pixel_run(input int r, input int g, input int b,
                           input int gap, input int hold, input bit last);
    int e;
    e = model(r, g, b);
    chk("pause_r", pause, 0);
    in_data = 8'(r); in_valid = 1'b1;
    tick();
    chk("pause_g", pause, 0);
    in_data = 8'(g);
    tick();
    repeat (gap) begin
      in_valid = 1'b0; in_data = 8'h5A;
      chk("pause_gap", pause, 0);
      chk("gv_gap", gray_valid, 0);
      tick();
    end
    in_valid = 1'b1; in_data = 8'(b);
    tick();
    in_data = 8'hEE; start = 1'b1;
    chk("pause_compute", pause, 1);
    chk("gv_compute", gray_valid, 0);
    tick();
    start = 1'b0;
    gray_ready = 1'b0;
    #1;
    repeat (hold) begin
      chk("gv_hold", gray_valid, 1);
      chk("data_hold", gray_data, e);
      chk("pause_hold", pause, 1);
      chk("done_hold", done, 0);
      tick();
    end
    gray_ready = 1'b1;
    #1;
    chk("gv_accept", gray_valid, 1);
    chk("data_accept", gray_data, e);
    chk("done_accept", done, last);
    chk("pause_accept", pause, 1);
    tick();
    gray_ready = 1'b0;
    #1;
    chk("gv_after", gray_valid, 0);
    chk("data_keep", gray_data, e);
    chk("pause_after", pause, last ? 1 : 0);
    chk("done_after", done, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int r0;
    int g0;
    int b0;
    rst_n = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0; gray_ready = 1'b0;
    tick();
    tick();
    chk("rst_pause", pause, 1);
    chk("rst_gv", gray_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_data", gray_data, 0);
    rst_n = 1'b1;
    tick();

    // Bytes offered in IDLE are ignored
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    chk("idle_pause", pause, 1);
    tick();
    chk("idle_pause2", pause, 1);

    // Frame 1: directed corner pixels then random ones
    do_start();
    pixel_run(255, 255, 255, 0, 0, 1'b0);
    pixel_run(0, 1, 0, 0, 0, 1'b0);
    pixel_run(100, 0, 0, 0, 5, 1'b0);
    pixel_run($urandom_range(255), $urandom_range(255), $urandom_range(255), 2, 0, 1'b0);
    pixel_run($urandom_range(255), $urandom_range(255), $urandom_range(255), 0, 1, 1'b0);
    pixel_run($urandom_range(255), $urandom_range(255), $urandom_range(255), 1, 2, 1'b1);
    tick();
    chk("idle_after_frame", pause, 1);

    // Frame 2: second start, random pixels, gaps and back-pressure
    do_start();
    for (int p = 0; p < 6; p++)
      pixel_run($urandom_range(255), $urandom_range(255), $urandom_range(255),
                $urandom_range(0, 2), $urandom_range(0, 3), p == 5);

    // Reset after the G byte discards the partial pixel and the pixel count
    do_start();
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_data = 8'h3C;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midpix_rst_pause", pause, 1);
    chk("midpix_rst_gv", gray_valid, 0);
    chk("midpix_rst_done", done, 0);
    chk("midpix_rst_data", gray_data, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("midpix_rst_idle", pause, 1);
    do_start();
    for (int p = 0; p < 6; p++)
      pixel_run($urandom_range(255), $urandom_range(255), $urandom_range(255),
                $urandom_range(0, 2), $urandom_range(0, 2), p == 5);

    // Reset while a result waits in OUTPUT
    do_start();
    r0 = $urandom_range(255); g0 = $urandom_range(255); b0 = $urandom_range(255);
    in_valid = 1'b1; in_data = 8'(r0);
    tick();
    in_data = 8'(g0);
    tick();
    in_data = 8'(b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("out_gv", gray_valid, 1);
    chk("out_data", gray_data, model(r0, g0, b0));
    rst_n = 1'b0;
    #1;
    chk("out_rst_gv", gray_valid, 0);
    chk("out_rst_data", gray_data, 0);
    chk("out_rst_pause", pause, 1);
    chk("out_rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("out_rst_idle", pause, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
